// File: rtl/ppu_cpu_reg_port_if.sv
// CPU-side register bus of the PPU: chip select, register index, direction,
// write data, and the read data / access-complete pulse returned by the port.
interface ppu_cpu_reg_port_if;
    logic       ppu_reg_cs;
    logic [2:0] ppu_reg_addr;
    logic       vram_WE;
    logic [7:0] cpu_data_in;
    logic [7:0] cpu_data_out;
    logic       rdy;

    modport master (
        output ppu_reg_cs, ppu_reg_addr, vram_WE, cpu_data_in,
        input  cpu_data_out, rdy
    );

    modport slave (
        input  ppu_reg_cs, ppu_reg_addr, vram_WE, cpu_data_in,
        output cpu_data_out, rdy
    );
endinterface

// File: rtl/ppu_cpu_reg_port.sv
// PPU register window ($2000-$2007) responder: control/mask, loopy scroll
// latches, VBlank status, PPUDATA buffering and the PPU-side VRAM/OAM strobes.
module ppu_cpu_reg_port #(
    parameter int unsigned VRAM_AW = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    ppu_cpu_reg_port_if.slave        bus,
    input  logic                     vblank_set,
    input  logic                     vblank_clr,
    input  logic                     sprite0_hit,
    input  logic                     sprite_ovf,
    input  logic [7:0]               oam_rd_data,
    output logic [7:0]               oam_addr,
    output logic [7:0]               oam_wr_data,
    output logic                     oam_we,
    output logic [VRAM_AW-1:0]       vram_addr,
    output logic [7:0]               vram_wr_data,
    output logic                     vram_we,
    output logic                     vram_re,
    input  logic [7:0]               vram_rd_data,
    output logic [7:0]               ppuctrl,
    output logic [7:0]               ppumask,
    output logic [14:0]              t_addr,
    output logic [14:0]              v_addr,
    output logic [2:0]               fine_x,
    output logic                     nmi
);

    typedef enum logic [1:0] {IDLE, DONE, RD_WAIT, INC} state_t;

    state_t      state_q, state_d;
    logic        cs_prev_q;
    logic        acc_we_q, acc_we_d;
    logic [2:0]  acc_addr_q, acc_addr_d;
    logic [7:0]  ppuctrl_q, ppuctrl_d;
    logic [7:0]  ppumask_q, ppumask_d;
    logic [14:0] t_q, t_d;
    logic [14:0] v_q, v_d;
    logic [2:0]  fine_x_q, fine_x_d;
    logic        w_q, w_d;
    logic        vblank_q, vblank_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_wr_data_q, oam_wr_data_d;
    logic [7:0]  vram_wr_data_q, vram_wr_data_d;
    logic        start;
    logic        status_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cs_prev_q      <= 1'b0;
            acc_we_q       <= 1'b0;
            acc_addr_q     <= '0;
            ppuctrl_q      <= '0;
            ppumask_q      <= '0;
            t_q            <= '0;
            v_q            <= '0;
            fine_x_q       <= '0;
            w_q            <= 1'b0;
            vblank_q       <= 1'b0;
            buf_q          <= '0;
            data_q         <= '0;
            oam_addr_q     <= '0;
            oam_wr_data_q  <= '0;
            vram_wr_data_q <= '0;
        end else begin
            state_q        <= state_d;
            cs_prev_q      <= bus.ppu_reg_cs;
            acc_we_q       <= acc_we_d;
            acc_addr_q     <= acc_addr_d;
            ppuctrl_q      <= ppuctrl_d;
            ppumask_q      <= ppumask_d;
            t_q            <= t_d;
            v_q            <= v_d;
            fine_x_q       <= fine_x_d;
            w_q            <= w_d;
            vblank_q       <= vblank_d;
            buf_q          <= buf_d;
            data_q         <= data_d;
            oam_addr_q     <= oam_addr_d;
            oam_wr_data_q  <= oam_wr_data_d;
            vram_wr_data_q <= vram_wr_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_we_d       = acc_we_q;
        acc_addr_d     = acc_addr_q;
        ppuctrl_d      = ppuctrl_q;
        ppumask_d      = ppumask_q;
        t_d            = t_q;
        v_d            = v_q;
        fine_x_d       = fine_x_q;
        w_d            = w_q;
        buf_d          = buf_q;
        data_d         = data_q;
        oam_addr_d     = oam_addr_q;
        oam_wr_data_d  = oam_wr_data_q;
        vram_wr_data_d = vram_wr_data_q;
        status_clr     = 1'b0;
        start          = !bus.ppu_reg_cs && cs_prev_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_we_d   = bus.vram_WE;
                    acc_addr_d = bus.ppu_reg_addr;
                    data_d     = '0;
                    state_d    = DONE;
                    if (bus.vram_WE) begin
                        unique case (bus.ppu_reg_addr)
                            3'd0: begin
                                ppuctrl_d   = bus.cpu_data_in;
                                t_d[11:10]  = bus.cpu_data_in[1:0];
                            end
                            3'd1: ppumask_d     = bus.cpu_data_in;
                            3'd3: oam_addr_d    = bus.cpu_data_in;
                            3'd4: oam_wr_data_d = bus.cpu_data_in;
                            3'd5: begin
                                if (!w_q) begin
                                    fine_x_d  = bus.cpu_data_in[2:0];
                                    t_d[4:0]  = bus.cpu_data_in[7:3];
                                end else begin
                                    t_d[14:12] = bus.cpu_data_in[2:0];
                                    t_d[9:5]   = bus.cpu_data_in[7:3];
                                end
                                w_d = ~w_q;
                            end
                            3'd6: begin
                                // second write copies the freshly completed t into v
                                if (!w_q) begin
                                    t_d[13:8] = bus.cpu_data_in[5:0];
                                    t_d[14]   = 1'b0;
                                end else begin
                                    t_d[7:0] = bus.cpu_data_in;
                                    v_d      = {t_q[14:8], bus.cpu_data_in};
                                end
                                w_d = ~w_q;
                            end
                            3'd7: begin
                                vram_wr_data_d = bus.cpu_data_in;
                                state_d        = INC;
                            end
                            default: ;
                        endcase
                    end else begin
                        unique case (bus.ppu_reg_addr)
                            3'd2: begin
                                data_d     = {vblank_q, sprite0_hit, sprite_ovf, 5'b0};
                                status_clr = 1'b1;
                                w_d        = 1'b0;
                            end
                            3'd4: data_d  = oam_rd_data;
                            3'd7: state_d = RD_WAIT;
                            default: ;
                        endcase
                    end
                end
            end
            RD_WAIT: state_d = INC;
            INC: begin
                v_d = v_q + (ppuctrl_q[2] ? 15'd32 : 15'd1);
                // VRAM data arrives this cycle; palette space bypasses the buffer
                if (!acc_we_q) begin
                    data_d = (v_q[13:8] == 6'h3F) ? vram_rd_data : buf_q;
                    buf_d  = vram_rd_data;
                end
                state_d = DONE;
            end
            DONE: begin
                if (acc_we_q && acc_addr_q == 3'd4)
                    oam_addr_d = oam_addr_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        vblank_d = vblank_q;
        if (vblank_set)
            vblank_d = 1'b1;
        else if (vblank_clr || status_clr)
            vblank_d = 1'b0;
    end

    assign bus.rdy          = (state_q == DONE);
    assign bus.cpu_data_out = data_q;
    assign oam_we           = (state_q == DONE) && acc_we_q && (acc_addr_q == 3'd4);
    assign vram_we          = (state_q == INC) && acc_we_q;
    assign vram_re          = (state_q == RD_WAIT);
    assign oam_addr         = oam_addr_q;
    assign oam_wr_data      = oam_wr_data_q;
    assign vram_addr        = v_q[VRAM_AW-1:0];
    assign vram_wr_data     = vram_wr_data_q;
    assign ppuctrl          = ppuctrl_q;
    assign ppumask          = ppumask_q;
    assign t_addr           = t_q;
    assign v_addr           = v_q;
    assign fine_x           = fine_x_q;
    assign nmi              = ppuctrl_q[7] & vblank_q;

endmodule

// File: tb/tb_ppu_cpu_reg_port.sv
// Bench for ppu_cpu_reg_port: vector table of register accesses with a read-data
// scoreboard, behavioural VRAM/OAM, plus hand sequences for VBlank and reset.
module tb_ppu_cpu_reg_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        vblank_set, vblank_clr, sprite0_hit, sprite_ovf;
    logic [7:0]  oam_rd_data, oam_addr, oam_wr_data;
    logic        oam_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wr_data, vram_rd_data;
    logic        vram_we, vram_re;
    logic [7:0]  ppuctrl, ppumask;
    logic [14:0] t_addr, v_addr;
    logic [2:0]  fine_x;
    logic        nmi;

    ppu_cpu_reg_port_if bus();

    ppu_cpu_reg_port #(.VRAM_AW(14)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr),
        .sprite0_hit(sprite0_hit), .sprite_ovf(sprite_ovf),
        .oam_rd_data(oam_rd_data), .oam_addr(oam_addr), .oam_wr_data(oam_wr_data),
        .oam_we(oam_we), .vram_addr(vram_addr), .vram_wr_data(vram_wr_data),
        .vram_we(vram_we), .vram_re(vram_re), .vram_rd_data(vram_rd_data),
        .ppuctrl(ppuctrl), .ppumask(ppumask), .t_addr(t_addr), .v_addr(v_addr),
        .fine_x(fine_x), .nmi(nmi)
    );

    always #5 clk = ~clk;

    logic [7:0]  vmem [0:16383];
    logic [7:0]  omem [0:255];
    int unsigned wr_cnt = 0;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;

    always @(posedge clk) begin
        if (vram_we) begin
            vmem[vram_addr] <= vram_wr_data;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= vram_addr;
            wr_data <= vram_wr_data;
        end
        if (vram_re) vram_rd_data <= vmem[vram_addr];
        if (oam_we)  omem[oam_addr] <= oam_wr_data;
    end
    assign oam_rd_data = omem[oam_addr];

    int errors = 0;
    int checks = 0;
    int unsigned rdy_cnt = 0;

    typedef struct { bit chk; logic [7:0] d; } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rdy) begin
            sb_t e;
            rdy_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got rdy=1 expected no access pending");
            end else begin
                e = sb_q.pop_front();
                if (e.chk) chk("rdata", {24'd0, bus.cpu_data_out}, {24'd0, e.d});
            end
        end
    end

    task automatic access(input bit we, input logic [2:0] a, input logic [7:0] d,
                          input bit cd, input logic [7:0] exp, input int unsigned exp_lat,
                          input int unsigned hold, input bit vs);
        int unsigned lat;
        bit seen;
        @(negedge clk);
        bus.ppu_reg_cs   = 1'b0;
        bus.ppu_reg_addr = a;
        bus.vram_WE      = we;
        bus.cpu_data_in  = d;
        vblank_set       = vs;
        sb_q.push_back('{cd, exp});
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int unsigned i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            vblank_set = 1'b0;
            lat++;
            if (bus.rdy) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: got no rdy expected rdy after %0d cycles", exp_lat);
            void'(sb_q.pop_front());
        end else begin
            chk("latency", lat, exp_lat);
        end
        for (int unsigned i = lat; i < hold; i++) @(negedge clk);
        bus.ppu_reg_cs = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit we; logic [2:0] a; logic [7:0] d; bit cd; logic [7:0] exp;
        int unsigned lat; int sel; logic [14:0] val;
    } vec_t;
    vec_t vt[$];

    function automatic logic [14:0] peek(input int sel);
        case (sel)
            1: return v_addr;
            2: return t_addr;
            3: return {7'd0, ppuctrl};
            4: return {12'd0, fine_x};
            5: return {7'd0, ppumask};
            6: return {7'd0, oam_addr};
            default: return '0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0;
        for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
        for (int i = 0; i < 256; i++) omem[i] = 8'h00;
        vmem[14'h2128] = 8'h55;
        vmem[14'h3F00] = 8'h0F;
        omem[8'h11]    = 8'hC3;
        vram_rd_data   = 8'h00;

        reset = 1'b1;
        bus.ppu_reg_cs = 1'b1; bus.ppu_reg_addr = '0; bus.vram_WE = 1'b0; bus.cpu_data_in = '0;
        vblank_set = 1'b0; vblank_clr = 1'b0; sprite0_hit = 1'b0; sprite_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_regs", {ppuctrl, ppumask, fine_x, 5'd0, oam_addr}, 32'd0);
        chk("reset_addr", {2'd0, t_addr, v_addr}, 32'd0);
        chk("reset_strobes", {bus.rdy, bus.cpu_data_out, oam_we, vram_we, vram_re, nmi,
                              oam_wr_data, vram_wr_data}, 32'd0);

        r0 = rdy_cnt;
        access(1'b1, 3'd0, 8'h84, 1'b0, 8'h00, 1, 4, 1'b0);
        chk("reg0_single_rdy", rdy_cnt - r0, 1);
        chk("reg0_ppuctrl", {24'd0, ppuctrl}, 32'h84);
        chk("reg0_t", {17'd0, t_addr}, 32'h0);

        vt.push_back('{1'b1, 3'd6, 8'h21, 1'b0, 8'h00, 1, 2, 15'h2100});
        vt.push_back('{1'b1, 3'd6, 8'h08, 1'b0, 8'h00, 1, 1, 15'h2108});
        vt.push_back('{1'b1, 3'd7, 8'hAB, 1'b0, 8'h00, 2, 1, 15'h2128});
        vt.push_back('{1'b0, 3'd7, 8'h00, 1'b1, 8'h00, 3, 1, 15'h2148});
        vt.push_back('{1'b0, 3'd7, 8'h00, 1'b1, 8'h55, 3, 1, 15'h2168});
        vt.push_back('{1'b1, 3'd6, 8'h3F, 1'b0, 8'h00, 1, 0, 15'h0});
        vt.push_back('{1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 1, 1, 15'h3F00});
        vt.push_back('{1'b0, 3'd7, 8'h00, 1'b1, 8'h0F, 3, 1, 15'h3F20});
        vt.push_back('{1'b1, 3'd1, 8'h1E, 1'b0, 8'h00, 1, 5, 15'h1E});
        vt.push_back('{1'b0, 3'd1, 8'h00, 1'b1, 8'h00, 1, 0, 15'h0});
        vt.push_back('{1'b1, 3'd2, 8'hFF, 1'b0, 8'h00, 1, 3, 15'h84});
        vt.push_back('{1'b1, 3'd3, 8'h10, 1'b0, 8'h00, 1, 6, 15'h10});
        vt.push_back('{1'b1, 3'd4, 8'h77, 1'b0, 8'h00, 1, 6, 15'h11});
        vt.push_back('{1'b0, 3'd4, 8'h00, 1'b1, 8'hC3, 1, 0, 15'h0});
        vt.push_back('{1'b1, 3'd5, 8'h7D, 1'b0, 8'h00, 1, 4, 15'h5});
        vt.push_back('{1'b1, 3'd5, 8'h5E, 1'b0, 8'h00, 1, 2, 15'h6D6F});

        foreach (vt[i]) begin
            access(vt[i].we, vt[i].a, vt[i].d, vt[i].cd, vt[i].exp, vt[i].lat, 1, 1'b0);
            if (vt[i].sel != 0) chk($sformatf("vec%0d_reg", i), {17'd0, peek(vt[i].sel)},
                                    {17'd0, vt[i].val});
        end
        chk("vram_write_count", wr_cnt, 1);
        chk("vram_write", {10'd0, wr_addr, wr_data}, {10'd0, 14'h2108, 8'hAB});
        chk("oam_write", {24'd0, omem[8'h10]}, 32'h77);

        @(negedge clk); vblank_set = 1'b1;
        @(negedge clk); vblank_set = 1'b0;
        chk("nmi_on_vblank", {31'd0, nmi}, 1);
        access(1'b0, 3'd2, 8'h00, 1'b1, 8'h80, 1, 1, 1'b0);
        chk("nmi_after_status", {31'd0, nmi}, 0);
        access(1'b0, 3'd2, 8'h00, 1'b1, 8'h00, 1, 1, 1'b1);
        chk("vblank_set_wins_read", {31'd0, nmi}, 1);
        @(negedge clk); vblank_set = 1'b1; vblank_clr = 1'b1;
        @(negedge clk); vblank_set = 1'b0; vblank_clr = 1'b0;
        chk("vblank_set_wins_clr", {31'd0, nmi}, 1);
        @(negedge clk); vblank_clr = 1'b1;
        @(negedge clk); vblank_clr = 1'b0;
        chk("vblank_clr", {31'd0, nmi}, 0);

        @(negedge clk);
        bus.ppu_reg_cs = 1'b0; bus.vram_WE = 1'b0; bus.ppu_reg_addr = 3'd7;
        @(posedge clk);
        @(negedge clk);
        chk("midread_vram_re", {31'd0, vram_re}, 1);
        r0 = rdy_cnt;
        reset = 1'b1;
        #1;
        chk("midreset_strobes", {bus.rdy, vram_re, vram_we, nmi, bus.cpu_data_out}, 32'd0);
        chk("midreset_state", {2'd0, v_addr, ppuctrl, ppumask}, 32'd0);
        repeat (2) @(negedge clk);
        bus.ppu_reg_cs = 1'b1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midreset_no_rdy", rdy_cnt - r0, 0);
        chk("midreset_t_fx", {14'd0, t_addr, fine_x}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
